// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front end and the control logic.
//   - command funct codes (the control logic decodes the same values)
//   - keypad key codes for the non-digit keys
//   - encoder state encoding
//   - helper that picks the funct for a loaded command
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam logic [2:0] FUNCT_ADD         = 3'b100;
    localparam logic [2:0] FUNCT_SUB         = 3'b101;
    localparam logic [2:0] FUNCT_ADD_TO_PREV = 3'b000;
    localparam logic [2:0] FUNCT_SUB_TO_PREV = 3'b001;

    localparam logic [3:0] KEY_PLUS   = 4'd10;
    localparam logic [3:0] KEY_MINUS  = 4'd11;
    localparam logic [3:0] KEY_EQUALS = 4'd12;
    localparam logic [3:0] KEY_CLEAR  = 4'd13;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_ISSUE = 2'd2,
        S_C     = 2'd3
    } calcState_t;

    // Keys 0..9 are digits; everything above is an operator or ignored.
    function automatic logic isDigitKey(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

    // A chained command works on the previous result, so it uses the
    // ToPrev flavour of the operator instead of the two-operand one.
    function automatic logic [2:0] cmdFunct(input logic chain, input logic op);
        if (chain) begin
            return op ? FUNCT_SUB_TO_PREV : FUNCT_ADD_TO_PREV;
        end
        return op ? FUNCT_SUB : FUNCT_ADD;
    endfunction

endpackage

// File: rtl/calc_cmd_encoder_if.sv
// ---------------------------------------------------------------------------
// calc_cmd_encoder_if
// Bundles the keypad-side and command-side handshakes of the encoder.
//   key_valid/key_code/key_ready : key stream from the keypad scanner
//   cmd_valid/cmd_ready          : command handshake to the control logic
//   cmd_funct/cmd_operand_a/b    : command payload
//   overflow                     : pulse when a digit was dropped
// Modports:
//   slave  : the encoder (consumes keys, produces commands)
//   master : the environment (keypad + control logic)
// ---------------------------------------------------------------------------
interface calc_cmd_encoder_if #(
    parameter int WIDTH = 16
);
    logic             key_valid;
    logic [3:0]       key_code;
    logic             key_ready;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_funct;
    logic [WIDTH-1:0] cmd_operand_a;
    logic [WIDTH-1:0] cmd_operand_b;
    logic             overflow;

    modport slave (
        input  key_valid, key_code, cmd_ready,
        output key_ready, cmd_valid, cmd_funct, cmd_operand_a, cmd_operand_b, overflow
    );

    modport master (
        output key_valid, key_code, cmd_ready,
        input  key_ready, cmd_valid, cmd_funct, cmd_operand_a, cmd_operand_b, overflow
    );
endinterface

// File: rtl/calc_digit_accum.sv
// ---------------------------------------------------------------------------
// calc_digit_accum
// Combinational decimal digit accumulator: computes x*10 + d with four
// guard bits and flags when the result no longer fits in WIDTH bits.
//   i_x        : current operand value
//   i_digit    : digit key code (only meaningful for 0..9)
//   o_next     : low WIDTH bits of x*10 + d
//   o_overflow : result exceeds 2^WIDTH-1, caller must keep x unchanged
// ---------------------------------------------------------------------------
module calc_digit_accum #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [3:0]       i_digit,
    output logic [WIDTH-1:0] o_next,
    output logic             o_overflow
);

    logic [WIDTH+3:0] w_wide;

    // Four extra bits are enough: 10*(2^WIDTH-1)+15 < 16*2^WIDTH.
    assign w_wide     = ({4'b0000, i_x} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, i_digit};
    assign o_next     = w_wide[WIDTH-1:0];
    assign o_overflow = |w_wide[WIDTH+3:WIDTH];

endmodule

// File: rtl/calc_cmd_encoder.sv
// ---------------------------------------------------------------------------
// calc_cmd_encoder
// Turns keypad key codes into complete calculator commands.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : calc_cmd_encoder_if.slave
//           keys in (valid/ready), commands out (valid/ready),
//           overflow pulse one cycle after a dropped digit
// ---------------------------------------------------------------------------
module calc_cmd_encoder
    import calc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    calc_cmd_encoder_if.slave bus
);

    calcState_t       r_state, w_stateNext;
    logic [WIDTH-1:0] r_a, w_aNext;
    logic [WIDTH-1:0] r_b, w_bNext;
    logic             r_op, w_opNext;
    logic             r_chain, w_chainNext;
    logic             r_bHasDigit, w_bHasDigitNext;
    logic             r_pendOp, w_pendOpNext;
    logic             r_pendValid, w_pendValidNext;
    logic [2:0]       r_funct, w_functNext;
    logic [WIDTH-1:0] r_cmdA, w_cmdANext;
    logic [WIDTH-1:0] r_cmdB, w_cmdBNext;
    logic             r_overflow, w_overflowNext;

    logic [WIDTH-1:0] w_accIn;
    logic [WIDTH-1:0] w_accOut;
    logic             w_accOvf;
    logic             w_keyFire;
    logic             w_cmdFire;
    logic             w_isDigit;
    logic             w_isOp;
    logic             w_newOp;

    // Only S_B accumulates into b; every other digit-accepting state
    // builds a, so a single accumulator is shared between the two.
    assign w_accIn = (r_state == S_B) ? r_b : r_a;

    calc_digit_accum #(.WIDTH(WIDTH)) u_accum (
        .i_x        (w_accIn),
        .i_digit    (bus.key_code),
        .o_next     (w_accOut),
        .o_overflow (w_accOvf)
    );

    assign w_keyFire = bus.key_valid && bus.key_ready;
    assign w_cmdFire = bus.cmd_valid && bus.cmd_ready;
    assign w_isDigit = isDigitKey(bus.key_code);
    assign w_isOp    = (bus.key_code == KEY_PLUS) || (bus.key_code == KEY_MINUS);
    assign w_newOp   = (bus.key_code == KEY_MINUS);

    assign bus.key_ready     = (r_state != S_ISSUE);
    assign bus.cmd_valid     = (r_state == S_ISSUE);
    assign bus.cmd_funct     = r_funct;
    assign bus.cmd_operand_a = r_cmdA;
    assign bus.cmd_operand_b = r_cmdB;
    assign bus.overflow      = r_overflow;

    // Next-state and register updates. Everything holds by default; a key
    // is only acted on outside S_ISSUE, and the command payload registers
    // are only written when a command is loaded so they stay stable for
    // the whole time cmd_valid is high.
    always_comb begin
        w_stateNext     = r_state;
        w_aNext         = r_a;
        w_bNext         = r_b;
        w_opNext        = r_op;
        w_chainNext     = r_chain;
        w_bHasDigitNext = r_bHasDigit;
        w_pendOpNext    = r_pendOp;
        w_pendValidNext = r_pendValid;
        w_functNext     = r_funct;
        w_cmdANext      = r_cmdA;
        w_cmdBNext      = r_cmdB;
        w_overflowNext  = 1'b0;

        if (w_keyFire) begin
            if (bus.key_code == KEY_CLEAR) begin
                w_stateNext     = S_A;
                w_aNext         = '0;
                w_bNext         = '0;
                w_opNext        = 1'b0;
                w_chainNext     = 1'b0;
                w_bHasDigitNext = 1'b0;
            end else begin
                case (r_state)
                    S_A: begin
                        if (w_isDigit) begin
                            if (w_accOvf) begin
                                w_overflowNext = 1'b1;
                            end else begin
                                w_aNext = w_accOut;
                            end
                        end else if (w_isOp) begin
                            w_opNext        = w_newOp;
                            w_chainNext     = 1'b0;
                            w_bNext         = '0;
                            w_bHasDigitNext = 1'b0;
                            w_stateNext     = S_B;
                        end
                    end
                    S_B: begin
                        if (w_isDigit) begin
                            w_bHasDigitNext = 1'b1;
                            if (w_accOvf) begin
                                w_overflowNext = 1'b1;
                            end else begin
                                w_bNext = w_accOut;
                            end
                        end else if (w_isOp && !r_bHasDigit) begin
                            w_opNext = w_newOp;
                        end else if ((w_isOp || bus.key_code == KEY_EQUALS) && r_bHasDigit) begin
                            w_functNext     = cmdFunct(r_chain, r_op);
                            w_cmdANext      = r_chain ? '0 : r_a;
                            w_cmdBNext      = r_b;
                            w_pendOpNext    = w_newOp;
                            w_pendValidNext = w_isOp;
                            w_stateNext     = S_ISSUE;
                        end
                    end
                    S_C: begin
                        if (w_isOp) begin
                            w_opNext        = w_newOp;
                            w_chainNext     = 1'b1;
                            w_bNext         = '0;
                            w_bHasDigitNext = 1'b0;
                            w_stateNext     = S_B;
                        end else if (w_isDigit) begin
                            w_aNext     = WIDTH'(bus.key_code);
                            w_chainNext = 1'b0;
                            w_stateNext = S_A;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end else if (w_cmdFire) begin
            if (r_pendValid) begin
                w_opNext        = r_pendOp;
                w_chainNext     = 1'b1;
                w_bNext         = '0;
                w_bHasDigitNext = 1'b0;
                w_stateNext     = S_B;
            end else begin
                w_stateNext = S_C;
            end
        end
    end

    // State and datapath registers; reset wins over any pending event,
    // including a command that is still waiting for cmd_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_A;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= 1'b0;
            r_chain     <= 1'b0;
            r_bHasDigit <= 1'b0;
            r_pendOp    <= 1'b0;
            r_pendValid <= 1'b0;
            r_funct     <= 3'b000;
            r_cmdA      <= '0;
            r_cmdB      <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_a         <= w_aNext;
            r_b         <= w_bNext;
            r_op        <= w_opNext;
            r_chain     <= w_chainNext;
            r_bHasDigit <= w_bHasDigitNext;
            r_pendOp    <= w_pendOpNext;
            r_pendValid <= w_pendValidNext;
            r_funct     <= w_functNext;
            r_cmdA      <= w_cmdANext;
            r_cmdB      <= w_cmdBNext;
            r_overflow  <= w_overflowNext;
        end
    end

endmodule

// File: tb/tb_calc_cmd_encoder.sv
// ---------------------------------------------------------------------------
// tb_calc_cmd_encoder
// Drives key codes into calc_cmd_encoder, keeps a calculator-level model of
// what commands the keys should produce, and compares every transferred
// command, the overflow pulse and key_ready against that model.
// ---------------------------------------------------------------------------
module tb_calc_cmd_encoder;

    localparam int     WIDTH = 16;
    localparam longint MAXV  = (longint'(1) << WIDTH) - 1;

    typedef struct packed {
        logic [2:0]       funct;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    logic clk;
    logic reset;

    calc_cmd_encoder_if #(.WIDTH(WIDTH)) bus ();

    calc_cmd_encoder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   vectors    = 0;
    int   miscompares = 0;
    int   readyPct   = 100;
    logic expOvf     = 1'b0;
    logic pendOvf    = 1'b0;
    cmd_t expQ[$];

    longint mA, mB;
    bit     mOp, mChain, mHaveB, enteringSecond, afterEquals;

    logic prevValid = 1'b0;
    logic prevFire  = 1'b0;
    cmd_t prevCmd;
    cmd_t monCmd;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bound the run in case the design wedges somewhere unexpected.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mA = 0; mB = 0; mOp = 0; mChain = 0; mHaveB = 0;
        enteringSecond = 0; afterEquals = 0;
        expQ.delete();
    endtask

    // A finished expression: two-operand form on a fresh expression,
    // "apply to previous result" form when continuing a chain.
    task automatic modelIssue();
        cmd_t c;
        c.funct = mChain ? {2'b00, mOp} : {2'b10, mOp};
        c.a     = mChain ? '0 : mA[WIDTH-1:0];
        c.b     = mB[WIDTH-1:0];
        expQ.push_back(c);
    endtask

    // Calculator semantics of one accepted key.
    task automatic modelKey(input logic [3:0] code);
        int     d;
        longint grown;
        bit     isDigit, isOp, isEq;
        d       = int'(code);
        isDigit = (d <= 9);
        isOp    = (d == 10) || (d == 11);
        isEq    = (d == 12);
        if (d == 13) begin
            mA = 0; mB = 0; mOp = 0; mChain = 0; mHaveB = 0;
            enteringSecond = 0; afterEquals = 0;
        end else if (afterEquals) begin
            if (isOp) begin
                mOp = (d == 11); mChain = 1; mB = 0; mHaveB = 0;
                afterEquals = 0; enteringSecond = 1;
            end else if (isDigit) begin
                mA = d; mChain = 0; afterEquals = 0; enteringSecond = 0;
            end
        end else if (!enteringSecond) begin
            if (isDigit) begin
                grown = mA * 10 + d;
                if (grown > MAXV) pendOvf = 1'b1;
                else mA = grown;
            end else if (isOp) begin
                mOp = (d == 11); mChain = 0; mB = 0; mHaveB = 0;
                enteringSecond = 1;
            end
        end else begin
            if (isDigit) begin
                grown = mB * 10 + d;
                mHaveB = 1;
                if (grown > MAXV) pendOvf = 1'b1;
                else mB = grown;
            end else if (isOp && !mHaveB) begin
                mOp = (d == 11);
            end else if (isOp) begin
                modelIssue();
                mOp = (d == 11); mChain = 1; mB = 0; mHaveB = 0;
            end else if (isEq && mHaveB) begin
                modelIssue();
                afterEquals = 1; enteringSecond = 0;
            end
        end
    endtask

    // One clock cycle of driving: check key_ready against the model, then
    // present the next inputs. Acceptance is decided by what the rising
    // edge will see.
    task automatic tick(input logic kv, input logic [3:0] kc, output bit accepted);
        @(negedge clk);
        expOvf  = pendOvf;
        pendOvf = 1'b0;
        checkOutput("key_ready", bus.key_ready, (expQ.size() == 0));
        bus.key_valid = kv;
        bus.key_code  = kc;
        bus.cmd_ready = ($urandom_range(0, 99) < readyPct);
        accepted = kv && (bus.key_ready === 1'b1);
        if (accepted) modelKey(kc);
    endtask

    // Present one key and hold it until the encoder takes it.
    task automatic applyStimulus(input logic [3:0] kc);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        while (!acc && n < 64) begin
            tick(1'b1, kc, acc);
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL key_accept: key %0d still not accepted, got %0d cycles, expected under 64", kc, n);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) tick(1'b0, 4'd0, acc);
    endtask

    // Command-side monitor: samples well clear of the clock edges, pops the
    // expected command whenever a transfer happens and checks that a
    // stalled command keeps its payload.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            prevValid = 1'b0;
            prevFire  = 1'b0;
        end else begin
            checkOutput("overflow", bus.overflow, expOvf);
            if (bus.cmd_valid === 1'b1 && prevValid && !prevFire) begin
                checkOutput("stall_funct", bus.cmd_funct, prevCmd.funct);
                checkOutput("stall_a", bus.cmd_operand_a, prevCmd.a);
                checkOutput("stall_b", bus.cmd_operand_b, prevCmd.b);
            end
            if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
                if (expQ.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_cmd: got funct %0d a %0d b %0d, expected no command",
                             bus.cmd_funct, bus.cmd_operand_a, bus.cmd_operand_b);
                end else begin
                    monCmd = expQ.pop_front();
                    checkOutput("cmd_funct", bus.cmd_funct, monCmd.funct);
                    checkOutput("cmd_operand_a", bus.cmd_operand_a, monCmd.a);
                    checkOutput("cmd_operand_b", bus.cmd_operand_b, monCmd.b);
                end
            end
            prevValid     = bus.cmd_valid;
            prevFire      = bus.cmd_valid && bus.cmd_ready;
            prevCmd.funct = bus.cmd_funct;
            prevCmd.a     = bus.cmd_operand_a;
            prevCmd.b     = bus.cmd_operand_b;
        end
    end

    // Main sequence: reset, directed scenarios, reset while a command is
    // stalled, then randomized keys with random back-pressure.
    initial begin
        bit acc;
        int r;
        logic [3:0] kc;

        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.cmd_ready = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset_cmd_valid", bus.cmd_valid, 0);
        checkOutput("reset_key_ready", bus.key_ready, 1);
        checkOutput("reset_funct", bus.cmd_funct, 0);
        checkOutput("reset_a", bus.cmd_operand_a, 0);
        checkOutput("reset_b", bus.cmd_operand_b, 0);
        checkOutput("reset_overflow", bus.overflow, 0);

        readyPct = 100;
        applyStimulus(1); applyStimulus(2); applyStimulus(10);
        applyStimulus(3); applyStimulus(4); applyStimulus(12);
        applyStimulus(10); applyStimulus(5); applyStimulus(12);
        applyStimulus(11); applyStimulus(2); applyStimulus(12);
        applyStimulus(7); applyStimulus(10); applyStimulus(11);
        applyStimulus(2); applyStimulus(12);

        applyStimulus(9); applyStimulus(10); applyStimulus(1);
        readyPct = 0;
        applyStimulus(10);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'd4, acc);
            checkOutput("stalled_key_taken", acc, 0);
        end
        readyPct = 100;
        applyStimulus(4); applyStimulus(12);

        applyStimulus(6); applyStimulus(5); applyStimulus(5);
        applyStimulus(3); applyStimulus(5); applyStimulus(9);
        applyStimulus(1); applyStimulus(10); applyStimulus(2);
        applyStimulus(13); applyStimulus(12);
        idle(4);

        applyStimulus(3); applyStimulus(10); applyStimulus(4);
        readyPct = 0;
        applyStimulus(12);
        idle(2);
        @(negedge clk);
        checkOutput("pre_reset_cmd_valid", bus.cmd_valid, 1);
        expOvf        = 1'b0;
        pendOvf       = 1'b0;
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.cmd_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkOutput("midreset_cmd_valid", bus.cmd_valid, 0);
        checkOutput("midreset_key_ready", bus.key_ready, 1);
        checkOutput("midreset_funct", bus.cmd_funct, 0);
        checkOutput("midreset_a", bus.cmd_operand_a, 0);
        checkOutput("midreset_b", bus.cmd_operand_b, 0);

        for (int k = 0; k < 300; k++) begin
            if (k % 50 == 0) readyPct = $urandom_range(30, 100);
            r = $urandom_range(0, 99);
            if (r < 55)      kc = 4'($urandom_range(0, 9));
            else if (r < 67) kc = 4'd10;
            else if (r < 79) kc = 4'd11;
            else if (r < 90) kc = 4'd12;
            else if (r < 94) kc = 4'd13;
            else             kc = 4'($urandom_range(14, 15));
            idle($urandom_range(0, 2));
            applyStimulus(kc);
        end

        readyPct = 100;
        idle(8);
        checkOutput("queue_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_cmd_encoder.md
Name: calc_cmd_encoder

Overview:
- Front end of the calculator. Turns a stream of keypad key codes into complete commands for the control logic.
- Each command is a 3-bit funct plus two operands, using the same encoding the control logic decodes (ADD, SUB, ADDToPrev, SUBToPrev).
- Sits between the keypad scanner and the control logic/datapath. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand width in bits (unsigned).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- key_valid  in  1  key_code is valid this cycle
- key_code  in  4  0-9 digit, 10 plus, 11 minus, 12 equals, 13 clear; 14-15 ignored
- key_ready  out  1  encoder accepts a key this cycle
- cmd_valid  out  1  command presented
- cmd_ready  in  1  downstream accepts command
- cmd_funct  out  3  100 ADD, 101 SUB, 000 ADDToPrev, 001 SUBToPrev
- cmd_operand_a  out  WIDTH  first operand; 0 for the ToPrev functs
- cmd_operand_b  out  WIDTH  second operand
- overflow  out  1  one-cycle pulse when a digit is dropped because of overflow

Behaviour:
- Key handshake: a key is accepted when key_valid && key_ready. key_ready = 1 in every state except S_ISSUE.
- Command handshake: a command transfers when cmd_valid && cmd_ready. cmd_funct and both operands stay stable while cmd_valid=1 and the command has not transferred.
- Reset: state S_A. Registers a, b, op, chain, b_has_digit all 0. Outputs: cmd_valid=0, cmd_funct=000, operands 0, overflow=0, key_ready=1.
- Reset has priority over every event, including reset mid-issue: cmd_valid=0 on the cycle after reset is sampled.
- Digit accumulate: next = x*10 + d, computed at WIDTH+4 bits.
  - If next > 2^WIDTH-1: x is unchanged and overflow pulses for one cycle.
  - Otherwise x <= next.
- Clear (13): in any state that accepts keys, go to S_A and zero a, b, op, chain, b_has_digit. No command is issued.
- S_A, entering the first operand:
  - Digit: accumulate into a.
  - Plus/minus: op <= 0/1, chain <= 0, b <= 0, b_has_digit <= 0, go to S_B.
  - Equals: ignored.
- S_B, entering the second operand:
  - Digit: accumulate into b, b_has_digit <= 1.
  - Plus/minus with b_has_digit=0: replaces op.
  - Plus/minus with b_has_digit=1: load the command, go to S_ISSUE, record the new op in pend_op with pend_valid=1.
  - Equals with b_has_digit=1: load the command, pend_valid=0, go to S_ISSUE.
  - Equals with b_has_digit=0: ignored.
- Command load:
  - chain=0: funct = {1, op}, operand_a = a.
  - chain=1: funct = {0, op}, operand_a = 0.
  - In both cases operand_b = b.
- S_ISSUE: cmd_valid=1, keys are stalled. On transfer, cmd_valid=0 in the next cycle, then:
  - pend_valid=1: op <= pend_op, chain <= 1, b <= 0, b_has_digit <= 0, go to S_B.
  - pend_valid=0: go to S_C.
- S_C, a previous result exists:
  - Plus/minus: op set, chain <= 1, b cleared, go to S_B.
  - Digit: start a fresh expression. a <= d, chain <= 0, go to S_A.
  - Equals: ignored.
- Latency: the command is presented on the cycle after the accepting key. At most one command is outstanding at a time.
- Key codes 14-15 are accepted and have no effect.

Decomposition:
- Package calc_pkg:
  - funct constants ADD/SUB/ADDToPrev/SUBToPrev, shared with the control logic
  - key code constants
  - state encoding S_A/S_B/S_ISSUE/S_C
- Sub-module calc_digit_accum: combinational x*10+d with overflow flag, parameterised by WIDTH. One instance is muxed onto a or b.

Test Plan:
- Keys 1,2,+,3,4,= with cmd_ready=1 -> one command: funct 100, a=12, b=34. State S_C afterwards.
- Continue with +,5,= -> funct 000, a=0, b=5. Then -,2,= -> funct 001, b=2.
- Keys 7,+,-,2,= -> single command: funct 101, a=7, b=2 (operator replaced).
- Keys 9,+,1,+,4,= -> first command funct 100, a=9, b=1, then funct 000, b=4. Hold cmd_ready=0 for 3 cycles on the first command: outputs stable, key_ready=0, no keys lost.
- WIDTH=16, keys 6,5,5,3,5,9 -> a=65535, overflow pulses once on the 9. Keys 1,+,2,clear,= -> no command, state S_A.
- Assert reset while cmd_valid=1 and cmd_ready=0 -> next cycle cmd_valid=0, key_ready=1, all operands 0.
